// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg
//   Shared types for the pipeline hazard controller: FSM state encoding,
//   the bundle of pipeline control outputs, and small helpers used by
//   hazard_ctrl to build that bundle.
//   Optional feature macro (used by hazard_ctrl): HAZARD_PERF_CNT_EN.
package hazard_ctrl_pkg;

   typedef enum logic {
      HZ_RUN      = 1'b0,
      HZ_MEM_WAIT = 1'b1
   } hz_state_e;

   // One field per pipeline control output, in port order.
   typedef struct packed {
      logic pc_stall;
      logic if_id_stall;
      logic id_ex_stall;
      logic ex_me_stall;
      logic id_ex_bubble;
      logic me_wb_bubble;
      logic if_id_flush;
      logic id_ex_flush;
   } hz_ctrl_t;

   localparam hz_ctrl_t HZ_CTRL_NONE = '0;

   // Whole-pipeline freeze for an outstanding data-memory access: every
   // register up to EX/MEM holds and a NOP enters MEM/WB.
   function automatic hz_ctrl_t hz_freeze();
      hz_ctrl_t c;
      c              = HZ_CTRL_NONE;
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_stall  = 1'b1;
      c.ex_me_stall  = 1'b1;
      c.me_wb_bubble = 1'b1;
      return c;
   endfunction

   // Kill the two younger instructions behind a taken branch in EX.
   function automatic hz_ctrl_t hz_flush();
      hz_ctrl_t c;
      c             = HZ_CTRL_NONE;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
      return c;
   endfunction

   // Hold PC and IF/ID for one cycle while a NOP goes into ID/EX.
   function automatic hz_ctrl_t hz_load_use_stall();
      hz_ctrl_t c;
      c              = HZ_CTRL_NONE;
      c.pc_stall     = 1'b1;
      c.if_id_stall  = 1'b1;
      c.id_ex_bubble = 1'b1;
      return c;
   endfunction

   // A load in EX feeds a source the ID instruction actually reads.
   // x0 is never a real dependency.
   function automatic logic hz_load_use(
      input logic       ex_mem_read,
      input logic [4:0] ex_rd,
      input logic [4:0] id_rs1,
      input logic [4:0] id_rs2,
      input logic       id_use_rs1,
      input logic       id_use_rs2
   );
      return ex_mem_read && (ex_rd != 5'd0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) ||
              (id_use_rs2 && (ex_rd == id_rs2)));
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// hazard_perf_cnt
//   Two free-running 32-bit event counters for hazard statistics.
//   Both wrap at 2^32 and clear on synchronous reset.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     inc_stall       count one stall cycle
//     inc_flush       count one flush cycle
//     stall_cycles    stall-cycle count
//     flush_count     flush-cycle count
module hazard_perf_cnt (
   input  logic        clk,
   input  logic        rst,
   input  logic        inc_stall,
   input  logic        inc_flush,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
);

   logic [31:0] stall_q, stall_d;
   logic [31:0] flush_q, flush_d;

   always_comb begin
      stall_d = stall_q + {31'd0, inc_stall};
      flush_d = flush_q + {31'd0, inc_flush};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cycles = stall_q;
   assign flush_count  = flush_q;

endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl
//   Stall/flush controller for the 5-stage pipeline. Handles what the
//   forwarding path cannot: load-use (one-cycle bubble), multi-cycle
//   data-memory waits (full freeze), and taken branches resolved in EX
//   (flush IF/ID and ID/EX). Outputs are combinational from state and
//   inputs so they act in the same cycle as their cause.
//   Parameters:
//     MEM_TIMEOUT  wait cycles after which mem_timeout_err sets
//     CNT_W        wait counter width, 2^CNT_W > MEM_TIMEOUT
//   Ports:
//     clk, rst                     clock, synchronous active-high reset
//     id_rs1/id_rs2, id_use_rs1/2  ID-stage sources and their use flags
//     ex_rd, ex_mem_read           EX destination, EX is a load
//     ex_branch_taken              EX resolved a taken branch/jump
//     me_mem_req, dmem_ready       MEM access request / completion
//     pc_stall .. ex_me_stall      pipeline register holds
//     id_ex_bubble, me_wb_bubble   NOP insertion
//     if_id_flush, id_ex_flush     pipeline register clears
//     mem_timeout_err              sticky memory timeout flag
//   Optional (macro HAZARD_PERF_CNT_EN):
//     stall_cycles, flush_count    32-bit performance counters
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16,
   parameter int unsigned CNT_W       = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] id_rs1,
   input  logic [4:0] id_rs2,
   input  logic       id_use_rs1,
   input  logic       id_use_rs2,
   input  logic [4:0] ex_rd,
   input  logic       ex_mem_read,
   input  logic       ex_branch_taken,
   input  logic       me_mem_req,
   input  logic       dmem_ready,
   output logic       pc_stall,
   output logic       if_id_stall,
   output logic       id_ex_stall,
   output logic       ex_me_stall,
   output logic       id_ex_bubble,
   output logic       me_wb_bubble,
   output logic       if_id_flush,
   output logic       id_ex_flush,
   output logic       mem_timeout_err
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [31:0] stall_cycles,
   output logic [31:0] flush_count
`endif
);

   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_TIMEOUT = CNT_W'(MEM_TIMEOUT);

   hz_state_e        state_q, state_d;
   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             flush_pend_q, flush_pend_d;
   logic             err_q, err_d;
   hz_ctrl_t         ctrl;

   logic mem_wait;
   logic load_use;

   assign mem_wait = me_mem_req && !dmem_ready;
   assign load_use = hz_load_use(ex_mem_read, ex_rd, id_rs1, id_rs2,
                                 id_use_rs1, id_use_rs2);

   always_comb begin
      state_d      = state_q;
      wait_cnt_d   = wait_cnt_q;
      flush_pend_d = flush_pend_q;
      err_d        = err_q;
      ctrl         = HZ_CTRL_NONE;

      unique case (state_q)
         HZ_RUN: begin
            if (mem_wait) begin
               ctrl         = hz_freeze();
               state_d      = HZ_MEM_WAIT;
               wait_cnt_d   = CNT_ONE;
               // A branch resolved in the entry cycle is replayed as a
               // flush when memory completes; the frozen pipeline keeps
               // the wrong-path instructions in place until then.
               flush_pend_d = ex_branch_taken;
               if (CNT_ONE >= CNT_TIMEOUT) begin
                  err_d = 1'b1;
               end
            end else if (ex_branch_taken) begin
               ctrl = hz_flush();
            end else if (load_use) begin
               ctrl = hz_load_use_stall();
            end
         end

         HZ_MEM_WAIT: begin
            if (!dmem_ready) begin
               ctrl = hz_freeze();
               if (wait_cnt_q != '1) begin
                  wait_cnt_d = wait_cnt_q + CNT_ONE;
               end
               // Flag and counter update on the same edge, so the flag is
               // visible from the first cycle the count equals the limit.
               if (wait_cnt_d >= CNT_TIMEOUT) begin
                  err_d = 1'b1;
               end
            end else begin
               if (flush_pend_q) begin
                  ctrl = hz_flush();
               end
               flush_pend_d = 1'b0;
               state_d      = HZ_RUN;
               wait_cnt_d   = '0;
            end
         end

         default: begin
            state_d = HZ_RUN;
         end
      endcase

      if (rst) begin
         ctrl = HZ_CTRL_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= HZ_RUN;
         wait_cnt_q   <= '0;
         flush_pend_q <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         wait_cnt_q   <= wait_cnt_d;
         flush_pend_q <= flush_pend_d;
         err_q        <= err_d;
      end
   end

   assign pc_stall        = ctrl.pc_stall;
   assign if_id_stall     = ctrl.if_id_stall;
   assign id_ex_stall     = ctrl.id_ex_stall;
   assign ex_me_stall     = ctrl.ex_me_stall;
   assign id_ex_bubble    = ctrl.id_ex_bubble;
   assign me_wb_bubble    = ctrl.me_wb_bubble;
   assign if_id_flush     = ctrl.if_id_flush;
   assign id_ex_flush     = ctrl.id_ex_flush;
   assign mem_timeout_err = rst ? 1'b0 : err_q;

`ifdef HAZARD_PERF_CNT_EN
   hazard_perf_cnt u_perf (
      .clk          (clk),
      .rst          (rst),
      .inc_stall    (ctrl.pc_stall),
      .inc_flush    (ctrl.if_id_flush),
      .stall_cycles (stall_cycles),
      .flush_count  (flush_count)
   );
`endif

endmodule
